spi_axi_wrapper: RTL and testbench
==================================

Name: spi_axi_wrapper

Overview:
- AXI4-Lite slave that bridges register accesses to a single-byte SPI master (mode 0, MSB first).
- Software writes a byte to TX_DATA, then writes 1 to TX_VALID to launch a transfer. The received byte is read back from RX_DATA, and completion is flagged in STATUS.
- Sits on the peripheral AXI-Lite bus and drives one external SPI slave.

Parameters:
- DATA_WIDTH, 32, AXI data width (only 32 supported).
- ADDR_WIDTH, 4, AXI address width; byte addresses, word aligned.
- CLK_DIV, 4, ACLK cycles per SCLK half-period (>=1).

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response, always 2'b00.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response, always 2'b00.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- clk  in  1  SPI core clock; must be tied to ACLK (single domain); internally unused beyond that.
- MISO  in  1  SPI serial in.
- MOSI  out  1  SPI serial out.
- SCLK  out  1  SPI clock, idle low.
- SS  out  1  slave select, active low.

Behaviour:
- Reset (ARESETN=0, async): AWREADY=WREADY=BVALID=ARREADY=RVALID=0; RDATA=0; TX_DATA=0; RX_DATA=0; busy=0; rx_valid_seen=0; SCLK=0; SS=1; MOSI=0. A transfer in progress is aborted.
- Register map:
  - 0x0 TX_DATA: RW, bits[7:0]; other bits read 0.
  - 0x4 TX_VALID: write-only start; reads return 0.
  - 0x8 RX_DATA: RO, bits[7:0].
  - 0xC STATUS: RO; bit0 = busy, bit1 = rx_valid_seen.
  - Other addresses: reads return 0, writes are ignored; response is still OKAY.
- Write channel:
  - When AWVALID && WVALID && !BVALID, AWREADY and WREADY pulse high together for exactly one cycle and the write takes effect.
  - BVALID rises on the next cycle and holds until BREADY is sampled high.
  - No new write is accepted while BVALID=1.
- TX_DATA is updated only when WSTRB[0]=1.
- A write to TX_VALID with WDATA[0]=1 while busy=0 starts a transfer and clears rx_valid_seen. The same write while busy=1 is ignored but still gets an OKAY response.
- Read channel:
  - When ARVALID && !RVALID, ARREADY pulses for one cycle.
  - On the next cycle RVALID=1 and RDATA is registered; RDATA stays stable until RREADY is sampled high.
  - Reading RX_DATA does not clear rx_valid_seen.
- Simultaneous read and write in the same cycle are both serviced. A STATUS read in that cycle returns the pre-write value.
- SPI FSM states:
  - IDLE: SS=1, SCLK=0.
  - On start -> LOAD: latch the shift register from TX_DATA, SS=0, MOSI=bit7, busy=1.
  - LOW: hold CLK_DIV cycles, then SCLK rises -> HIGH; sample MISO into the shift-register LSB.
  - HIGH: hold CLK_DIV cycles, then SCLK falls. If 8 bits are done -> DONE; else shift and drive the next bit on MOSI -> LOW.
  - DONE: SS=1, RX_DATA = received byte, rx_valid_seen=1, busy=0 -> IDLE.
- Transfer latency: start write to rx_valid_seen = 16*CLK_DIV + 2 cycles (±1 cycle).
- SCLK toggles only while SS=0. Exactly 8 rising edges per transfer.
- rx_valid_seen is an internal register of that exact name and stays set until the next start or reset.

Test Plan:
- Reset, then read all four registers -> all 0x0; SS=1, SCLK=0.
- Loopback MISO=MOSI; write 0x0=0xA5, then 0x4=0x1; wait rx_valid_seen; read 0x8 -> 0x000000A5, STATUS=0x2. Check exactly 8 SCLK rising edges with SS low.
- MISO tied 0; send 0xFF -> RX_DATA=0x00. MISO tied 1; send 0x00 -> RX_DATA=0xFF. MOSI bit order MSB first.
- Write 0x4=0x1 while busy -> BVALID with BRESP=0, RX_DATA equals the first byte only, and only 8 SCLK edges.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable; next write is not accepted until B completes.
- Deassert ARESETN mid-transfer -> SS=1, SCLK=0 immediately, busy=0; a new transfer afterwards completes correctly.

Source files
------------

// File: rtl/spi_axi_wrapper.sv
// spi_axi_wrapper: AXI4-Lite register slave launching single-byte SPI mode-0 transfers, MSB first.
module spi_axi_wrapper #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic                      clk,
    input  logic                      MISO,
    output logic                      MOSI,
    output logic                      SCLK,
    output logic                      SS
);
    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_t;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_TX = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] A_GO = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] A_RX = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] A_ST = ADDR_WIDTH'(4'hC);
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            tx_data, rx_data, shreg;
    logic                  busy, rx_valid_seen, start, cnt_done;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_ok;
    // AWREADY marks the cycle in which the write is committed
    assign start     = AWREADY && AWADDR == A_GO && WDATA[0] && !busy;
    assign cnt_done  = cnt == CW'(CLK_DIV - 1);
    assign BRESP     = 2'b00;
    assign RRESP     = 2'b00;
    assign unused_ok = ^{WSTRB[DATA_WIDTH/8-1:1], WDATA[DATA_WIDTH-1:8]};
    assign rd_mux    = (ARADDR == A_TX) ? DATA_WIDTH'(tx_data) :
                       (ARADDR == A_RX) ? DATA_WIDTH'(rx_data) :
                       (ARADDR == A_ST) ? DATA_WIDTH'({rx_valid_seen, busy}) : '0;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            tx_data <= '0;
        end else begin
            AWREADY <= AWVALID && WVALID && !BVALID && !AWREADY;
            WREADY  <= AWVALID && WVALID && !BVALID && !AWREADY;
            BVALID  <= AWREADY || (BVALID && !BREADY);
            if (AWREADY && AWADDR == A_TX && WSTRB[0])
                tx_data <= WDATA[7:0];
            ARREADY <= ARVALID && !RVALID && !ARREADY;
            RVALID  <= ARREADY || (RVALID && !RREADY);
            if (ARREADY)
                RDATA <= rd_mux;
        end
    end
    // MISO is shifted in at the SCLK rise; MOSI takes the new MSB at the fall
    always_ff @(posedge clk or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            busy          <= 1'b0;
            rx_valid_seen <= 1'b0;
            SCLK          <= 1'b0;
            SS            <= 1'b1;
            MOSI          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shreg         <= tx_data;
                    MOSI          <= tx_data[7];
                    SS            <= 1'b0;
                    busy          <= 1'b1;
                    rx_valid_seen <= 1'b0;
                    state         <= LOAD;
                end
                LOAD: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    state   <= LOW;
                end
                LOW: if (cnt_done) begin
                    cnt   <= '0;
                    SCLK  <= 1'b1;
                    shreg <= {shreg[6:0], MISO};
                    state <= HIGH;
                end else cnt <= cnt + 1'b1;
                HIGH: if (cnt_done) begin
                    cnt  <= '0;
                    SCLK <= 1'b0;
                    if (bit_cnt == 3'd7) state <= DONE;
                    else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        MOSI    <= shreg[7];
                        state   <= LOW;
                    end
                end else cnt <= cnt + 1'b1;
                DONE: begin
                    SS            <= 1'b1;
                    MOSI          <= 1'b0;
                    rx_data       <= shreg;
                    rx_valid_seen <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_axi_wrapper.sv
// tb_spi_axi_wrapper: randomized register/SPI traffic checked against a transaction-level model.
module tb_spi_axi_wrapper;
    localparam int CD = 4;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0, wstrb = '0;
    logic [31:0] wdata = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        miso, mosi, sclk, ss;
    int          checks = 0, failures = 0, cyc = 0, rises = 0, rbase = 0, k;
    int          wr_cyc, rd_cyc;
    logic        lb = 1'b0;
    logic [7:0]  s_byte = '0, mosi_cap = '0;
    logic [7:0]  m_tx = '0, m_rx = '0;
    logic        m_rvs = 1'b0;

    spi_axi_wrapper #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CLK_DIV(CD)) dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .clk(aclk), .MISO(miso), .MOSI(mosi), .SCLK(sclk), .SS(ss)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;
    always @(posedge sclk) if (!ss) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], mosi};
    end
    // SPI slave: presents s_byte MSB first, one bit per completed SCLK period
    assign k    = rises - rbase;
    assign miso = lb ? mosi : (k >= 0 && k < 8) ? s_byte[3'(7 - k)] : 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a)
            4'h0:    return {24'h0, m_tx};
            4'h8:    return {24'h0, m_rx};
            4'hC:    return {30'h0, m_rvs, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int hold, input logic pend, input logic [31:0] pd);
        int n;
        @(negedge aclk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge aclk); n++; end
        chk("awready", awready, 1);
        chk("wready", wready, 1);
        wr_cyc = cyc + 1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("awready_pulse", awready, 0);
        chk("bvalid", bvalid, 1);
        if (pend) begin
            awaddr = 4'h0; wdata = pd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1);
            if (pend) chk("aw_blocked", awready, 0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_clr", bvalid, 0);
    endtask

    task automatic rd(input logic [3:0] a, input int hold, output logic [31:0] d);
        int n;
        @(negedge aclk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge aclk); n++; end
        chk("arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        chk("rvalid", rvalid, 1);
        d = rdata;
        rd_cyc = cyc;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, d);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk("rvalid_clr", rvalid, 0);
    endtask

    task automatic rd_chk(input logic [3:0] a);
        logic [31:0] d;
        rd(a, 0, d);
        chk($sformatf("read_%0h", a), d, exp_read(a));
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input logic loop, input logic restart);
        logic [31:0] d;
        int polls, base, st;
        lb = loop; s_byte = sb;
        wr(4'h0, {24'hC0FFEE, tx}, 4'h1, 0, 1'b0, 0);
        m_tx = tx;
        base = rises; rbase = rises;
        wr(4'h4, 32'h1, 4'hF, 0, 1'b0, 0);
        st = wr_cyc; m_rvs = 1'b0;
        if (restart) begin
            wr(4'h4, 32'h1, 4'hF, 0, 1'b0, 0);
            wr(4'h0, {24'h0, ~tx}, 4'h1, 0, 1'b0, 0);
            m_tx = ~tx;
        end
        polls = 0; d = 0;
        while (d != 32'h2 && polls < 60) begin
            rd(4'hC, 0, d);
            chk("status_poll", (d == 32'h1 || d == 32'h2), 1);
            polls++;
        end
        chk("status_done", d, 32'h2);
        chk("latency", (rd_cyc - st >= 16*CD + 2 && rd_cyc - st <= 16*CD + 12), 1);
        m_rx = loop ? tx : sb; m_rvs = 1'b1;
        repeat (20) @(negedge aclk);
        chk("sclk_rises", rises - base, 8);
        chk("mosi_byte", mosi_cap, tx);
        chk("ss_idle", ss, 1);
        rd_chk(4'h8);
        rd_chk(4'hC);
        rd_chk(4'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        fork
            forever begin
                @(negedge aclk);
                if (ss) chk("sclk_idle_low", sclk, 0);
                if (bvalid) chk("bresp", bresp, 0);
                if (rvalid) chk("rresp", rresp, 0);
            end
        join_none
        repeat (3) @(negedge aclk);
        chk("rst_ss", ss, 1); chk("rst_sclk", sclk, 0); chk("rst_mosi", mosi, 0);
        chk("rst_bvalid", bvalid, 0); chk("rst_rvalid", rvalid, 0); chk("rst_awready", awready, 0);
        aresetn = 1'b1;
        for (int a = 0; a < 16; a += 4) begin
            rd(4'(a), 0, d);
            chk("reset_read", d, 32'h0);
        end
        xfer(8'hA5, 8'h00, 1'b1, 1'b0);
        rd(4'h8, 0, d); chk("lit_rx_a5", d, 32'h0000_00A5);
        rd(4'hC, 0, d); chk("lit_status", d, 32'h2);
        rd(4'h4, 0, d); chk("lit_txvalid_rd", d, 32'h0);
        xfer(8'hFF, 8'h00, 1'b0, 1'b0);
        rd(4'h8, 0, d); chk("lit_rx_00", d, 32'h0);
        xfer(8'h00, 8'hFF, 1'b0, 1'b0);
        rd(4'h8, 0, d); chk("lit_rx_ff", d, 32'hFF);
        xfer(8'h3C, 8'h81, 1'b1, 1'b1);
        rd(4'h8, 0, d); chk("lit_rx_busy_restart", d, 32'h3C);
        wr(4'h0, 32'h11, 4'hF, 5, 1'b1, 32'h22);
        wr(4'h0, 32'h22, 4'hF, 0, 1'b0, 0);
        m_tx = 8'h22;
        rd(4'h0, 5, d); chk("lit_tx_after_hold", d, 32'h22);
        wr(4'h0, 32'h77, 4'hE, 0, 1'b0, 0);
        rd_chk(4'h0);
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            wr(4'h0, d, s, 0, 1'b0, 0);
            if (s[0]) m_tx = d[7:0];
            rd_chk(4'h0);
            xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        lb = 1'b1;
        wr(4'h0, 32'h5A, 4'h1, 0, 1'b0, 0);
        wr(4'h4, 32'h1, 4'h1, 0, 1'b0, 0);
        repeat (30) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("abort_ss", ss, 1);
        chk("abort_sclk", sclk, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_tx = '0; m_rx = '0; m_rvs = 1'b0;
        rd_chk(4'hC);
        rd_chk(4'h0);
        rd_chk(4'h8);
        xfer(8'hC3, 8'h96, 1'b0, 1'b0);
        rd(4'h8, 0, d); chk("lit_rx_after_abort", d, 32'h96);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
